// File: rtl/sarray_mem_resp.sv
// sarray_mem_resp: single-port-per-direction word array with an in-order,
// flow-controlled read response path.
//   - AR channel: one read per cycle, throttled by an outstanding-read limit.
//   - R channel: responses leave an in-order FIFO after a fixed read latency.
//   - AW channel: address+data together, always accepted, full-word write.
// Optional build macro: SARRAY_MEM_RESP_PERF_EN adds saturating performance
// counters (reads, writes, read stall cycles).
//
// Handshake rule for every channel: a transfer happens in a cycle exactly when
// valid and ready are both high at the rising clock edge; valid never depends
// on ready, and ar_ready_o depends only on registered state.
module sarray_mem_resp #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_SHIFT = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [DATA_WIDTH-1:0] aw_data_i
`ifdef SARRAY_MEM_RESP_PERF_EN
  ,
  output logic [31:0]           perf_rd_cnt_o,
  output logic [31:0]           perf_wr_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);

  logic                  ar_hs;
  logic                  r_hs;
  logic                  aw_hs;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  unused_addr_bits;

  logic [DATA_WIDTH-1:0] mem      [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  // Address bits outside the word index are intentionally ignored (wrap).
  assign unused_addr_bits = ^{ar_addr_i, aw_addr_i};

  assign aw_ready_o = 1'b1;
  assign ar_hs      = ar_valid_i && ar_ready_o;
  assign r_hs       = r_valid_o && r_ready_i;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign rd_idx     = ar_addr_i[ADDR_SHIFT +: DEPTH_LOG2];
  assign wr_idx     = aw_addr_i[ADDR_SHIFT +: DEPTH_LOG2];

  // Read sees the array before this cycle's write lands (old data on collision).
  assign rd_word    = mem[rd_idx];

  // Outstanding limit is registered, so r_ready_i never reaches ar_ready_o.
  assign ar_ready_o = (outstanding < CW'(FIFO_DEPTH));
  assign r_valid_o  = (fifo_cnt != '0);
  assign r_data_o   = fifo_mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Array write port: contents are never reset.
  always_ff @(posedge clk) begin
    if (aw_hs) mem[wr_idx] <= aw_data_i;
  end

  // Read pipeline: RD_LAT-1 register stages ahead of the FIFO write.
  generate
    if (RD_LAT == 1) begin : g_no_pipe
      assign push_valid = ar_hs;
      assign push_data  = rd_word;
    end else begin : g_pipe
      logic [RD_LAT-2:0]     pv;
      logic [DATA_WIDTH-1:0] pd [RD_LAT-1];

      // Stage valids; cleared on reset so in-flight reads are discarded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
        end else begin
          pv[0] <= ar_hs;
          for (int k = 1; k < RD_LAT - 1; k++) pv[k] <= pv[k-1];
        end
      end

      // Stage data; qualified by the valids above, so no reset needed.
      always_ff @(posedge clk) begin
        if (ar_hs) pd[0] <= rd_word;
        for (int k = 1; k < RD_LAT - 1; k++) pd[k] <= pd[k-1];
      end

      assign push_valid = pv[RD_LAT-2];
      assign push_data  = pd[RD_LAT-2];
    end
  endgenerate

  // Response FIFO storage; space is guaranteed by the outstanding limit.
  always_ff @(posedge clk) begin
    if (push_valid) fifo_mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (r_hs)       rd_ptr <= ptr_inc(rd_ptr);
      case ({push_valid, r_hs})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Reads accepted but not yet returned on R (pipeline plus FIFO).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef SARRAY_MEM_RESP_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt_o    <= '0;
      perf_wr_cnt_o    <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (ar_hs && (perf_rd_cnt_o != '1))
        perf_rd_cnt_o <= perf_rd_cnt_o + 32'd1;
      if (aw_hs && (perf_wr_cnt_o != '1))
        perf_wr_cnt_o <= perf_wr_cnt_o + 32'd1;
      if (ar_valid_i && !ar_ready_o && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sarray_mem_resp.md
SARRAY_MEM_RESP -- requirements
Module: sarray_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: byte address width.
REQ-002 Parameter DATA_WIDTH, default 256: read and write data width.
REQ-003 Parameter DEPTH_LOG2, default 10: log2 of the number of array words.
REQ-004 Parameter ADDR_SHIFT, default 8: address low bits dropped to form the word index (256-byte row stride).
REQ-005 Parameter RD_LAT, default 2: read pipeline stages, range 1..4.
REQ-006 Parameter FIFO_DEPTH, default 4: read response FIFO entries, SHALL be >= RD_LAT+1.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 ar_valid_i  in  1  read request valid.
REQ-010 ar_ready_o  out  1  read request accepted when high with ar_valid_i.
REQ-011 ar_addr_i  in  ADDR_WIDTH  read byte address.
REQ-012 r_valid_o  out  1  read data valid.
REQ-013 r_ready_i  in  1  read data consumed when high with r_valid_o.
REQ-014 r_data_o  out  DATA_WIDTH  read data.
REQ-015 aw_valid_i  in  1  write request valid; address and data travel together.
REQ-016 aw_ready_o  out  1  write accepted; constant 1.
REQ-017 aw_addr_i  in  ADDR_WIDTH  write byte address.
REQ-018 aw_data_i  in  DATA_WIDTH  write data, full-word write, no byte enables.

Function
REQ-019 Word index SHALL be addr[ADDR_SHIFT+DEPTH_LOG2-1:ADDR_SHIFT]; lower and upper bits ignored, so out-of-range addresses wrap modulo 2^DEPTH_LOG2.
REQ-020 The array SHALL support one read and one write per cycle; a write on aw handshake updates the word at the next clock edge.
REQ-021 A read SHALL sample the array in its AR handshake cycle; a same-cycle write to the same word returns the old data; later writes do not affect an accepted read.
REQ-022 Outstanding count (accepted reads not yet returned on R) SHALL be 0..FIFO_DEPTH; +1 on AR handshake, -1 on R handshake, unchanged when both occur together.
REQ-023 ar_ready_o SHALL equal (outstanding < FIFO_DEPTH); no combinational path from r_ready_i to ar_ready_o.
REQ-024 Read data for an AR handshake in cycle t SHALL enter the response FIFO at edge t+RD_LAT and give r_valid_o=1 in cycle t+RD_LAT at the earliest; no bypass.
REQ-025 Responses SHALL return in request order; r_valid_o = FIFO non-empty; r_data_o = FIFO head, held stable while r_valid_o && !r_ready_i.
REQ-026 With r_ready_i=1 continuously, back-to-back AR handshakes SHALL sustain one read per cycle with no bubbles.
REQ-027 FIFO full never overflows: the outstanding limit guarantees space for every in-flight pipeline entry.
REQ-028 aw_valid_i with aw_ready_o=1 SHALL write every cycle it is high, regardless of read state.

Reset
REQ-029 On rst_n low: outstanding=0, pipeline valids cleared, FIFO empty, r_valid_o=0, ar_ready_o=1, aw_ready_o=1; r_data_o value is don't-care.
REQ-030 Array contents SHALL NOT be reset; in-flight reads at reset assertion SHALL be discarded and never returned.

Configuration
REQ-031 Macro SARRAY_MEM_RESP_PERF_EN defined: add outputs perf_rd_cnt_o[31:0] (AR handshakes), perf_wr_cnt_o[31:0] (AW handshakes), perf_stall_cnt_o[31:0] (cycles with ar_valid_i && !ar_ready_o); each saturates at 32'hFFFFFFFF and resets to 0.
REQ-032 Macro undefined: these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 Write word 5 (addr 0x500) = 0xA5..A5, then read 0x500 -> r_valid_o exactly 2 cycles after AR handshake, r_data_o = 0xA5..A5.
REQ-034 Same-cycle AW and AR to addr 0x300 (old 0x11.., new 0x22..) -> read returns 0x11..; next read returns 0x22...
REQ-035 r_ready_i=0, issue 5 reads -> 4 accepted, ar_ready_o=0 from the 5th; one R handshake -> ar_ready_o=1 next cycle; 4 responses returned in order.
REQ-036 16 back-to-back reads of addresses 0x0..0xF00, r_ready_i=1 -> 16 responses in 16 consecutive cycles, matching data.
REQ-037 Read of addr 0x40000 (DEPTH_LOG2=10) -> returns word 0 (wrap); rst_n pulse with 2 reads in flight -> no r_valid_o afterwards, ar_ready_o=1.
REQ-038 With SARRAY_MEM_RESP_PERF_EN: 3 reads, 2 writes, 4 stall cycles -> counters read 3, 2, 4.
